// File: rtl/vector_alu_pipe_if.sv
// Operand/result handshake bundle for vector_alu_pipe: slave is the ALU side,
// master is the operand issuer / result consumer side.
interface vector_alu_pipe_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    logic                        in_valid;
    logic                        in_ready;
    logic [N-1:0][WIDTH-1:0]     A;
    logic [N-1:0][WIDTH-1:0]     B;
    logic [N-1:0][2:0]           sel;
    logic [N-1:0]                enable;
    logic                        out_valid;
    logic                        out_ready;
    logic [N-1:0][2*WIDTH-1:0]   Z;
    logic [N-1:0]                dz;

    modport master (
        output in_valid, A, B, sel, enable, out_ready,
        input  in_ready, out_valid, Z, dz
    );

    modport slave (
        input  in_valid, A, B, sel, enable, out_ready,
        output in_ready, out_valid, Z, dz
    );
endinterface

// File: rtl/vector_alu_pipe.sv
// N-lane vector ALU with a registered valid/ready result stage.
// Define VALU_DIV_EN to build the per-lane iterative restoring divider.
module vector_alu_pipe #(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              arst,
    vector_alu_pipe_if.slave bus
);
    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t                 state_q, state_d;
    logic [N-1:0][W2-1:0]   z_q;
    logic [N-1:0]           dz_q;
    logic                   accept;
    logic                   divStart;

    function automatic logic [W2-1:0] laneOp(input logic [2:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
        logic [W2-1:0] ax, bx, r;
        ax = W2'(a);
        bx = W2'(b);
        case (op)
            3'b000:  r = ax + bx;
            3'b001:  r = ax - bx;
            3'b010:  r = ax & bx;
            3'b011:  r = ax | bx;
            3'b100:  r = ax * bx;
            3'b110:  r = ax ^ bx;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.Z         = z_q;
    assign bus.dz        = dz_q;

`ifdef VALU_DIV_EN
    localparam int         CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [2:0] OP_DIV = 3'b101;

    logic [CW-1:0]            cnt_q;
    logic [N-1:0]             divLane_q;
    logic [N-1:0][WIDTH-1:0]  divisor_q, rem_q, quo_q, rem_d, quo_d;
    logic [N-1:0][WIDTH:0]    trial;

    always_comb begin
        divStart = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (bus.enable[i] && (bus.sel[i] == OP_DIV)) divStart = 1'b1;
        end
    end

    // One restoring step per lane: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            trial[i] = {rem_q[i], quo_q[i][WIDTH-1]};
            if (trial[i] >= {1'b0, divisor_q[i]}) begin
                rem_d[i] = WIDTH'(trial[i] - {1'b0, divisor_q[i]});
                quo_d[i] = {quo_q[i][WIDTH-2:0], 1'b1};
            end else begin
                rem_d[i] = trial[i][WIDTH-1:0];
                quo_d[i] = {quo_q[i][WIDTH-2:0], 1'b0};
            end
        end
    end
`else
    assign divStart = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = divStart ? DIV : DONE;
            end
            DIV: begin
`ifdef VALU_DIV_EN
                if (cnt_q == '0) state_d = DONE;
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                if (accept)             state_d = divStart ? DIV : DONE;
                else if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Non-divide lanes resolve at accept; divide lanes are written on the last step.
    always_ff @(posedge clk) begin
        if (arst) begin
            z_q  <= '0;
            dz_q <= '0;
`ifdef VALU_DIV_EN
            cnt_q     <= '0;
            divLane_q <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
`endif
        end else if (accept) begin
            for (int i = 0; i < N; i++) begin
                z_q[i] <= bus.enable[i] ? laneOp(bus.sel[i], bus.A[i], bus.B[i]) : '0;
`ifdef VALU_DIV_EN
                dz_q[i]      <= bus.enable[i] && (bus.sel[i] == OP_DIV) && (bus.B[i] == '0);
                divLane_q[i] <= bus.enable[i] && (bus.sel[i] == OP_DIV);
`else
                dz_q[i] <= 1'b0;
`endif
            end
`ifdef VALU_DIV_EN
            cnt_q     <= CW'(WIDTH - 1);
            divisor_q <= bus.B;
            quo_q     <= bus.A;
            rem_q     <= '0;
`endif
        end
`ifdef VALU_DIV_EN
        else if (state_q == DIV) begin
            cnt_q <= cnt_q - CW'(1);
            rem_q <= rem_d;
            quo_q <= quo_d;
            if (cnt_q == '0) begin
                for (int i = 0; i < N; i++) begin
                    if (divLane_q[i]) z_q[i] <= dz_q[i] ? '0 : W2'(quo_d[i]);
                end
            end
        end
`endif
    end
endmodule

// File: tb/tb_vector_alu_pipe.sv
// Scoreboard bench for vector_alu_pipe; the lane model follows VALU_DIV_EN
// so the same bench serves both builds.
module tb_vector_alu_pipe;
    localparam int N     = 4;
    localparam int WIDTH = 8;
`ifdef VALU_DIV_EN
    localparam int DIV_LAT = WIDTH + 1;
`else
    localparam int DIV_LAT = 1;
`endif

    typedef struct {
        logic [N-1:0][2*WIDTH-1:0] z;
        logic [N-1:0]              dz;
    } exp_t;

    logic clk;
    logic arst;

    vector_alu_pipe_if #(.N(N), .WIDTH(WIDTH)) bus ();

    vector_alu_pipe #(.N(N), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .arst(arst),
        .bus (bus)
    );

    exp_t   expQ[$];
    exp_t   monE;
    int     total   = 0;
    int     bad     = 0;
    int     retired = 0;
    bit     randReady = 1'b0;
    longint lastAccept = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference lane behaviour in plain integer arithmetic, truncated to 2*WIDTH bits.
    function automatic exp_t model(input logic [N-1:0][WIDTH-1:0] a,
                                   input logic [N-1:0][WIDTH-1:0] b,
                                   input logic [N-1:0][2:0]       sel,
                                   input logic [N-1:0]            en);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            int x, y, r;
            x = int'(a[i]);
            y = int'(b[i]);
            r = 0;
            e.dz[i] = 1'b0;
            if (en[i]) begin
                case (sel[i])
                    3'd0: r = x + y;
                    3'd1: r = x - y;
                    3'd2: r = x & y;
                    3'd3: r = x | y;
                    3'd4: r = x * y;
                    3'd5: begin
`ifdef VALU_DIV_EN
                        if (y == 0) e.dz[i] = 1'b1;
                        else        r = x / y;
`endif
                    end
                    3'd6: r = x ^ y;
                    default: r = 0;
                endcase
            end
            e.z[i] = r[2*WIDTH-1:0];
        end
        return e;
    endfunction

    // Retire results in order and police the held output while stalled.
    always @(negedge clk) begin
        if (!arst && bus.out_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected out_valid", 64'd1, 64'd0);
            end else if (bus.out_ready) begin
                monE = expQ.pop_front();
                checkOutput("Z", bus.Z, monE.z);
                checkOutput("dz", 64'(bus.dz), 64'(monE.dz));
                retired++;
            end else begin
                checkOutput("held Z", bus.Z, expQ[0].z);
                checkOutput("held dz", 64'(bus.dz), 64'(expQ[0].dz));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (randReady) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic applyStimulus(input logic [N-1:0][WIDTH-1:0] a,
                                 input logic [N-1:0][WIDTH-1:0] b,
                                 input logic [N-1:0][2:0]       sel,
                                 input logic [N-1:0]            en);
        bit done = 1'b0;
        bus.A        = a;
        bus.B        = b;
        bus.sel      = sel;
        bus.enable   = en;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                expQ.push_back(model(a, b, sel, en));
                lastAccept = longint'($time);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checkOutput("accept timeout", 64'd0, 64'd1);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic measureLatency(input string name,
                                  input logic [N-1:0][WIDTH-1:0] a,
                                  input logic [N-1:0][WIDTH-1:0] b,
                                  input logic [N-1:0][2:0]       sel,
                                  input logic [N-1:0]            en,
                                  input int                      want);
        bit seen     = 1'b0;
        bit sawReady = 1'b0;
        int lat      = -1;
        applyStimulus(a, b, sel, en);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                lat  = int'((longint'($time) - lastAccept) / 10);
            end else if (bus.in_ready) begin
                sawReady = 1'b1;
            end
        end
        checkOutput({name, " latency"}, 64'(lat), 64'(want));
        checkOutput({name, " in_ready while busy"}, 64'(sawReady), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0][WIDTH-1:0] a, b;
        logic [N-1:0][2:0]       s;
        logic [N-1:0]            en;
        int                      base;
        longint                  t0;

        arst          = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.sel       = '0;
        bus.enable    = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 arst = 1'b0;
        @(negedge clk);
        checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("reset in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("reset Z", bus.Z, 64'd0);
        checkOutput("reset dz", 64'(bus.dz), 64'd0);
        @(posedge clk);
        #1;

        // Directed vectors; lane 0 is the least significant element.
        a = {8'd15, 8'hF0, 8'd3, 8'd200};
        b = {8'd17, 8'h3C, 8'd5, 8'd100};
        s = {3'b100, 3'b010, 3'b001, 3'b000};
        measureLatency("mixed", a, b, s, 4'hF, 1);

        a = {8'd1, 8'd2, 8'd3, 8'd200};
        b = {8'd4, 8'd5, 8'd6, 8'd7};
        s = {3'b000, 3'b000, 3'b000, 3'b101};
        measureLatency("div200by7", a, b, s, 4'hF, DIV_LAT);

        a = {8'd8, 8'd8, 8'd8, 8'd8};
        b = {8'd2, 8'd2, 8'd2, 8'd2};
        s = {3'b101, 3'b101, 3'b101, 3'b101};
        measureLatency("div8by2", a, b, s, 4'hF, DIV_LAT);

        a = {8'd50, 8'd77, 8'd9, 8'd1};
        b = {8'd60, 8'd0, 8'd0, 8'd2};
        s = {3'b000, 3'b101, 3'b101, 3'b010};
        measureLatency("divzero mask", a, b, s, 4'b1011, DIV_LAT);

        a = {8'd4, 8'd3, 8'd2, 8'd90};
        b = {8'd1, 8'd1, 8'd1, 8'd3};
        s = {3'b111, 3'b110, 3'b011, 3'b101};
        measureLatency("masked div", a, b, s, 4'b1110, 1);

        // Reset in the middle of a divide discards the vector.
        a = {8'd1, 8'd1, 8'd1, 8'd100};
        b = {8'd1, 8'd1, 8'd1, 8'd9};
        s = {3'b000, 3'b000, 3'b000, 3'b101};
        applyStimulus(a, b, s, 4'hF);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 arst = 1'b1;
        repeat (2) @(posedge clk);
        #1 arst = 1'b0;
        expQ.delete();
        @(negedge clk);
        checkOutput("midreset out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("midreset in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("midreset Z", bus.Z, 64'd0);
        checkOutput("midreset dz", 64'(bus.dz), 64'd0);
        repeat (12) @(negedge clk);
        @(posedge clk);
        #1;

        // Backpressure then back-to-back throughput.
        bus.out_ready = 1'b0;
        a = {8'd10, 8'd20, 8'd30, 8'd255};
        b = {8'd11, 8'd21, 8'd31, 8'd255};
        applyStimulus(a, b, '0, 4'hF);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 20 && !bus.out_valid; k++) @(negedge clk);
        checkOutput("stall out_valid", 64'(bus.out_valid), 64'd1);
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall in_ready", 64'(bus.in_ready), 64'd0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        base = retired;
        t0   = longint'($time);
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < N; i++) begin
                a[i] = WIDTH'($urandom);
                b[i] = WIDTH'($urandom);
            end
            applyStimulus(a, b, '0, 4'hF);
        end
        checkOutput("b2b cycles", 64'((longint'($time) - t0) / 10), 64'd10);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("b2b retired", 64'(retired - base), 64'd11);
        @(posedge clk);
        #1;

        // Randomised traffic with random consumer stalls.
        randReady = 1'b1;
        for (int n = 0; n < 150; n++) begin
            for (int i = 0; i < N; i++) begin
                a[i] = WIDTH'($urandom);
                b[i] = ($urandom_range(0, 4) == 0) ? '0 : WIDTH'($urandom);
                s[i] = 3'($urandom_range(0, 7));
            end
            en = N'($urandom);
            applyStimulus(a, b, s, en);
            if ($urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        bus.in_valid = 1'b0;
        randReady    = 1'b0;
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        for (int k = 0; k < 60 && expQ.size() != 0; k++) @(negedge clk);
        checkOutput("drain", 64'(expQ.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
